sobel_frame_ctrl: RTL and testbench

Frame sequencer for the Sobel pixel pipeline (RGB-to-grayscale, Sobel kernel, grayscale-to-RGB chain).
- On a start pulse it generates the read addresses for one IMG_W x IMG_H source frame and issues one pixel per cycle into the pipeline, qualified by a valid strobe.
- It counts the pipeline's output done strobes and generates matching write addresses for the result buffer.
- It signals frame completion, or a drain timeout if the pipeline stops producing outputs.

---
 rtl/sobel_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel pipeline: issues one source read per cycle,
// tracks result writes and reports frame completion or a drain timeout.
module sobel_frame_ctrl #(
    parameter int unsigned IMG_W         = 640,
    parameter int unsigned IMG_H         = 480,
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              pix_valid_o,
    input  logic              pipe_done_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              timeout_err_o
);
    localparam int unsigned PIX_N = IMG_W * IMG_H;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned WD_W  = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);
    localparam logic [CNT_W-1:0]  PIX_CNT   = CNT_W'(PIX_N);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PIX_N - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
    logic              timeout_q, timeout_d;
    logic              pix_valid_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              active;
    logic              last_wr;

    // Result strobes count only while a frame is running and not yet full
    assign active  = (state_q == ISSUE) || (state_q == DRAIN);
    assign wr_en_o = pipe_done_i && active && (out_cnt_q < PIX_CNT);
    assign last_wr = wr_en_o && (out_cnt_q == LAST_CNT);

    // A strobe clears the watchdog in its own cycle, so the count restarts at 1
    assign wd_inc = (pipe_done_i ? WD_W'(0) : wd_q) + WD_W'(1);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        out_cnt_d = out_cnt_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        rd_en_o   = 1'b0;

        if (wr_en_o) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = ISSUE;
                    rd_addr_d = '0;
                    out_cnt_d = '0;
                    wd_d      = '0;
                    timeout_d = 1'b0;
                end
            end
            ISSUE: begin
                wd_d = '0;
                if (!hold_i) begin
                    rd_en_o = 1'b1;
                    // Address holds at the last pixel so it never wraps
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                wd_d = wd_inc;
                if ((out_cnt_q == PIX_CNT) || last_wr) begin
                    state_d = DONE;
                end else if (!pipe_done_i && (wd_inc == WD_LIMIT)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            out_cnt_q    <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            out_cnt_q    <= out_cnt_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            pix_valid_q  <= rd_en_o;
            busy_q       <= (state_d == ISSUE) || (state_d == DRAIN);
            frame_done_q <= (state_d == DONE);
        end
    end

    assign rd_addr_o     = rd_addr_q;
    assign wr_addr_o     = out_cnt_q[ADDR_W-1:0];
    assign pix_valid_o   = pix_valid_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;
    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 3;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TMO    = 8;
    localparam int          N      = IMG_W * IMG_H;
    localparam int          T      = TMO;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              hold_i = 1'b0;
    logic              pipe_done_i = 1'b0;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              pix_valid_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              busy_o;
    logic              frame_done_o;
    logic              timeout_err_o;

    sobel_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .hold_i(hold_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .pix_valid_o(pix_valid_o),
        .pipe_done_i(pipe_done_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model: frame in progress, reads issued, writes accepted, drain deadline
    bit m_in_frame, m_done, m_err, m_pv;
    int m_issued, m_writes, m_deadline, m_cyc;

    // DUT observations for the literal checks
    int cur_k;
    int o_first_rd, o_last_rd, o_n_rd, o_n_wr, o_last_wr_addr, o_n_done, o_done_k, o_to_k1;
    int o_addr [64];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pv = 1'b0;
        m_issued = 0; m_writes = 0; m_deadline = -1;
    endtask

    function automatic bit exp_rd();
        return (rst === 1'b1) && m_in_frame && (m_issued < N) && (hold_i !== 1'b1);
    endfunction

    function automatic bit exp_wr();
        return (rst === 1'b1) && m_in_frame && (pipe_done_i === 1'b1) && (m_writes < N);
    endfunction

    task automatic compare_outputs();
        bit e_rd;
        bit e_wr;
        e_rd = exp_rd();
        e_wr = exp_wr();
        chk("rd_en", int'(rd_en_o), int'(e_rd));
        if (e_rd) chk("rd_addr", int'(rd_addr_o), m_issued);
        chk("pix_valid", int'(pix_valid_o), int'(m_pv));
        chk("wr_en", int'(wr_en_o), int'(e_wr));
        if (e_wr) chk("wr_addr", int'(wr_addr_o), m_writes);
        chk("busy", int'(busy_o), int'(m_in_frame));
        chk("frame_done", int'(frame_done_o), int'(m_done));
        chk("timeout_err", int'(timeout_err_o), int'(m_err));
    endtask

    // Advance the model across one rising edge using the inputs of the ending cycle
    task automatic advance();
        bit e_rd;
        bit e_wr;
        int cur;
        cur = m_cyc;
        m_cyc++;
        if (rst === 1'b1) begin
            e_rd = exp_rd();
            e_wr = exp_wr();
            m_pv = e_rd;
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_in_frame) begin
                if (start_i === 1'b1) begin
                    m_in_frame = 1'b1; m_issued = 0; m_writes = 0; m_err = 1'b0;
                end
            end else if (m_issued == N) begin
                if (e_wr) m_writes++;
                if (m_writes == N) begin
                    m_in_frame = 1'b0; m_done = 1'b1;
                end else begin
                    if (pipe_done_i === 1'b1) m_deadline = cur + T;
                    if (cur + 1 == m_deadline) begin
                        m_in_frame = 1'b0; m_done = 1'b1; m_err = 1'b1;
                    end
                end
            end else begin
                if (e_wr) m_writes++;
                if (e_rd) begin
                    m_issued++;
                    if (m_issued == N) m_deadline = cur + 1 + T;
                end
            end
        end
    endtask

    task automatic obs_clear();
        o_first_rd = -1; o_last_rd = -1; o_n_rd = 0; o_n_wr = 0;
        o_last_wr_addr = -1; o_n_done = 0; o_done_k = -1; o_to_k1 = -1;
        for (int i = 0; i < 64; i++) o_addr[i] = -1;
    endtask

    task automatic observe();
        if (cur_k >= 0 && cur_k < 64) o_addr[cur_k] = int'(rd_addr_o);
        if (rd_en_o === 1'b1) begin
            o_n_rd++;
            if (o_first_rd < 0) o_first_rd = cur_k;
            o_last_rd = cur_k;
        end
        if (wr_en_o === 1'b1) begin
            o_n_wr++;
            o_last_wr_addr = int'(wr_addr_o);
        end
        if (frame_done_o === 1'b1) begin
            o_n_done++;
            o_done_k = cur_k;
        end
        if (cur_k == 1) o_to_k1 = int'(timeout_err_o);
    endtask

    // Inputs are applied 1 ns after the rising edge; outputs are checked on the falling edge
    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        observe();
        @(posedge clk);
        advance();
        #1;
    endtask

    // One frame: start in cycle 0, then hold window, echoed (or random) strobes, extra starts
    task automatic frame(input int hold_lo, input int hold_hi, input int echo_limit,
                         input int extra, input int restart_a, input int restart_b,
                         input bit rnd, input int stop_k);
        bit pvq[$];
        int echoed;
        int extra_left;
        int done_k;
        obs_clear();
        echoed = 0; extra_left = extra; done_k = -1;
        cur_k = 0; start_i = 1'b1; hold_i = 1'b0; pipe_done_i = 1'b0;
        pvq.push_back(m_pv);
        cycle();
        start_i = 1'b0;
        for (int k = 1; k <= stop_k; k++) begin
            cur_k = k;
            pvq.push_back(m_pv);
            if (rnd) begin
                hold_i      = ($urandom_range(0, 99) < 25);
                pipe_done_i = ($urandom_range(0, 99) < 40);
                start_i     = (done_k < 0) && ($urandom_range(0, 99) < 8);
            end else begin
                hold_i      = (k >= hold_lo) && (k <= hold_hi);
                start_i     = (k == restart_a) || (k == restart_b);
                pipe_done_i = 1'b0;
                if (k >= 6 && pvq[k-6] && echoed < echo_limit) begin
                    pipe_done_i = 1'b1;
                    echoed++;
                end else if (echoed >= echo_limit && extra_left > 0) begin
                    pipe_done_i = 1'b1;
                    extra_left--;
                end
            end
            cycle();
            if (m_done && done_k < 0) done_k = k + 1;
            if (done_k >= 0 && k >= done_k + 3) break;
        end
        start_i = 1'b0; hold_i = 1'b0; pipe_done_i = 1'b0; cur_k = -1;
        if (stop_k >= 100) chk("frame_completes", int'(done_k >= 0), 1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_en"}, int'(rd_en_o), 0);
        chk({name, "_pix_valid"}, int'(pix_valid_o), 0);
        chk({name, "_busy"}, int'(busy_o), 0);
        chk({name, "_frame_done"}, int'(frame_done_o), 0);
        chk({name, "_rd_addr"}, int'(rd_addr_o), 0);
        chk({name, "_wr_addr"}, int'(wr_addr_o), 0);
        chk({name, "_timeout"}, int'(timeout_err_o), 0);
    endtask

    initial begin
        m_cyc = 0;
        cur_k = -1;
        model_reset();
        obs_clear();

        // Power-on reset
        repeat (3) cycle();
        chk_zero("por");
        rst = 1'b1;
        cycle();

        // Reset in the middle of ISSUE while rd_addr is 5
        frame(100, -1, N, 0, -1, -1, 1'b0, 6);
        chk("mid_reset_addr5", o_addr[6], 5);
        rst = 1'b0;
        model_reset();
        #1;
        chk_zero("mid_reset");
        repeat (2) cycle();
        rst = 1'b1;
        cycle();

        // Nominal frame, strobes echo pix_valid 6 cycles later
        frame(100, -1, N, 0, -1, -1, 1'b0, 150);
        chk("nom_first_rd_cycle", o_first_rd, 1);
        chk("nom_first_rd_addr", o_addr[1], 0);
        chk("nom_last_rd_cycle", o_last_rd, 12);
        chk("nom_reads", o_n_rd, 12);
        chk("nom_writes", o_n_wr, 12);
        chk("nom_last_wr_addr", o_last_wr_addr, 11);
        chk("nom_done_pulses", o_n_done, 1);
        chk("nom_done_cycle", o_done_k, 20);
        chk("nom_timeout", int'(timeout_err_o), 0);
        repeat (2) cycle();

        // Back-pressure in cycles 3..5
        frame(3, 5, N, 0, -1, -1, 1'b0, 150);
        for (int k = 3; k <= 6; k++) chk("bp_addr_held", o_addr[k], 2);
        chk("bp_addr_resume", o_addr[7], 3);
        chk("bp_last_rd_cycle", o_last_rd, 15);
        chk("bp_reads", o_n_rd, 12);
        chk("bp_done_cycle", o_done_k, 23);
        repeat (2) cycle();

        // Starved drain: only 10 strobes
        frame(100, -1, 10, 0, -1, -1, 1'b0, 150);
        chk("starve_writes", o_n_wr, 10);
        chk("starve_last_wr_addr", o_last_wr_addr, 9);
        chk("starve_done_cycle", o_done_k, 25);
        chk("starve_timeout_flag", int'(timeout_err_o), 1);
        repeat (2) cycle();

        // Strobes while idle, then a frame with 3 strobes past the 12th
        obs_clear();
        pipe_done_i = 1'b1;
        repeat (3) cycle();
        pipe_done_i = 1'b0;
        chk("idle_strobes_writes", o_n_wr, 0);
        frame(100, -1, N, 3, -1, -1, 1'b0, 150);
        chk("start_clears_timeout", o_to_k1, 0);
        chk("spur_writes", o_n_wr, 12);
        chk("spur_last_wr_addr", o_last_wr_addr, 11);
        chk("spur_done_cycle", o_done_k, 20);
        repeat (2) cycle();

        // Start pulses while busy (cycle 4 and during drain)
        frame(100, -1, N, 0, 4, 15, 1'b0, 150);
        chk("busy_start_addr4", o_addr[4], 3);
        chk("busy_start_reads", o_n_rd, 12);
        chk("busy_start_done_pulses", o_n_done, 1);
        chk("busy_start_done_cycle", o_done_k, 20);
        repeat (2) cycle();

        // Randomized hold, strobes and stray starts
        for (int f = 0; f < 10; f++) begin
            frame(0, -1, 0, 0, -1, -1, 1'b1, 200);
            repeat (2) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
